// File: rtl/uart_word_packer_if.sv
// rtl/uart_word_packer_if.sv - UART-side memory write port between packer and request handler
interface uart_word_packer_if;
   logic        write_from_UART;
   logic        read_from_UART;
   logic [31:0] adr_from_UART;
   logic [31:0] data_from_UART;
   logic [3:0]  sel_from_UART;
   logic        UART_enable;
   logic        mem_busy;

   modport master (
      output write_from_UART, read_from_UART, adr_from_UART, data_from_UART, sel_from_UART,
      input  UART_enable, mem_busy
   );

   modport slave (
      input  write_from_UART, read_from_UART, adr_from_UART, data_from_UART, sel_from_UART,
      output UART_enable, mem_busy
   );
endinterface

// File: rtl/uart_word_packer.sv
// rtl/uart_word_packer.sv - packs UART bytes into little-endian words, buffers them in a FIFO
// and writes them to sequential memory addresses when the request handler grants the UART port.
module uart_word_packer #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter logic [31:0] ADDR_SPAN  = 32'h0000_1000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      nRst,
   input  logic [7:0]                rx_data,
   input  logic                      rx_valid,
   input  logic                      flush,
   input  logic                      load_start,
   uart_word_packer_if.master        mem,
   output logic                      fifo_full,
   output logic                      overrun,
   output logic [15:0]               words_written
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
   localparam logic [31:0] LAST_ADDR = BASE_ADDR + ADDR_SPAN - 32'd4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic [1:0]  state;
   logic [31:0] addr_ptr;

   logic [31:0] asm_word;
   logic [3:0]  asm_sel;
   logic [1:0]  byte_cnt;

   logic [35:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic [35:0]   head;

   logic [31:0] byte_shifted;
   logic [31:0] merged_word;
   logic [3:0]  merged_sel;
   logic        push_req;
   logic [31:0] push_word;
   logic [3:0]  push_sel;
   logic        push_ok;
   logic        pop;
   logic        writing;

   // The incoming byte is merged first so a flush in the same cycle sees it.
   always_comb begin
      byte_shifted = {24'b0, rx_data} << {byte_cnt, 3'b000};
      merged_word  = asm_word | byte_shifted;
      merged_sel   = asm_sel | (4'b0001 << byte_cnt);
      if (rx_valid) begin
         push_req  = (byte_cnt == 2'd3) || flush;
         push_word = merged_word;
         push_sel  = merged_sel;
      end else begin
         push_req  = flush && (byte_cnt != 2'd0);
         push_word = asm_word;
         push_sel  = asm_sel;
      end
   end

   assign fifo_full = (count == FULL_CNT);
   assign pop       = (state == S_REQ) && mem.UART_enable && !mem.mem_busy && !load_start;
   assign push_ok   = push_req && !load_start && (!fifo_full || pop);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         asm_word <= 32'h0;
         asm_sel  <= 4'h0;
         byte_cnt <= 2'd0;
         overrun  <= 1'b0;
      end else if (load_start) begin
         asm_word <= 32'h0;
         asm_sel  <= 4'h0;
         byte_cnt <= 2'd0;
         overrun  <= 1'b0;
      end else if (push_req) begin
         asm_word <= 32'h0;
         asm_sel  <= 4'h0;
         byte_cnt <= 2'd0;
         if (!push_ok)
            overrun <= 1'b1;
      end else if (rx_valid) begin
         asm_word <= merged_word;
         asm_sel  <= merged_sel;
         byte_cnt <= byte_cnt + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         fifo_mem[wr_ptr] <= {push_sel, push_word};
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (load_start) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(push_ok) - (PW+1)'(pop);
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state         <= S_IDLE;
         addr_ptr      <= BASE_ADDR;
         words_written <= 16'h0;
      end else if (load_start) begin
         state         <= S_IDLE;
         addr_ptr      <= BASE_ADDR;
         words_written <= 16'h0;
      end else begin
         case (state)
            S_IDLE: if ((count != '0) && mem.UART_enable) state <= S_REQ;
            S_REQ: begin
               if (pop) begin
                  state         <= S_GAP;
                  addr_ptr      <= (addr_ptr == LAST_ADDR) ? BASE_ADDR : addr_ptr + 32'd4;
                  words_written <= words_written + 16'd1;
               end
            end
            // One idle cycle so memory sees a request boundary between words.
            S_GAP:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign head    = fifo_mem[rd_ptr];
   assign writing = (state == S_REQ);

   assign mem.write_from_UART = writing;
   assign mem.read_from_UART  = 1'b0;
   assign mem.adr_from_UART   = writing ? addr_ptr : 32'h0;
   assign mem.data_from_UART  = writing ? head[31:0] : 32'h0;
   assign mem.sel_from_UART   = writing ? head[35:32] : 4'h0;
endmodule

// File: tb/tb_uart_word_packer.sv
// tb/tb_uart_word_packer.sv - directed self-checking bench for uart_word_packer
module tb_uart_word_packer;
   localparam logic [31:0] BASE = 32'h0000_0100;
   localparam logic [31:0] SPAN = 32'h0000_0040;

   logic        clk = 1'b0;
   logic        nRst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        flush;
   logic        load_start;
   logic        fifo_full;
   logic        overrun;
   logic [15:0] words_written;

   int vectors     = 0;
   int miscompares = 0;
   int wr_seen     = 0;
   int ws0;

   uart_word_packer_if mem();

   uart_word_packer #(.BASE_ADDR(BASE), .ADDR_SPAN(SPAN), .FIFO_DEPTH(4)) dut (
      .clk           (clk),
      .nRst          (nRst),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .flush         (flush),
      .load_start    (load_start),
      .mem           (mem),
      .fifo_full     (fifo_full),
      .overrun       (overrun),
      .words_written (words_written)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (nRst && !load_start && mem.write_from_UART && mem.UART_enable && !mem.mem_busy)
         wr_seen <= wr_seen + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!mem.write_from_UART && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_req"}, 32'(mem.write_from_UART), 32'd1);
   endtask

   task automatic expect_write(input string tag, input logic [31:0] adr,
                               input logic [31:0] data, input logic [3:0] sel);
      wait_req(tag);
      chk({tag, "_adr"},  mem.adr_from_UART, adr);
      chk({tag, "_data"}, mem.data_from_UART, data);
      chk({tag, "_sel"},  32'(mem.sel_from_UART), 32'(sel));
      step();
      chk({tag, "_gap"},  32'(mem.write_from_UART), 32'd0);
   endtask

   initial begin
      nRst = 1'b0; rx_data = 8'h0; rx_valid = 1'b0; flush = 1'b0; load_start = 1'b0;
      mem.UART_enable = 1'b0; mem.mem_busy = 1'b0;
      step(); step();
      chk("rst_write", 32'(mem.write_from_UART), 32'd0);
      chk("rst_read",  32'(mem.read_from_UART), 32'd0);
      chk("rst_adr",   mem.adr_from_UART, 32'd0);
      chk("rst_data",  mem.data_from_UART, 32'd0);
      chk("rst_sel",   32'(mem.sel_from_UART), 32'd0);
      chk("rst_full",  32'(fifo_full), 32'd0);
      chk("rst_ovr",   32'(overrun), 32'd0);
      chk("rst_words", 32'(words_written), 32'd0);
      nRst = 1'b1;
      step();

      // full word and two-edge latency
      mem.UART_enable = 1'b1;
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      chk("lat_n", 32'(mem.write_from_UART), 32'd0);
      step();
      chk("w1_write", 32'(mem.write_from_UART), 32'd1);
      chk("w1_adr",   mem.adr_from_UART, BASE);
      chk("w1_data",  mem.data_from_UART, 32'h44332211);
      chk("w1_sel",   32'(mem.sel_from_UART), 32'hF);
      step();
      chk("w1_gap",   32'(mem.write_from_UART), 32'd0);
      chk("w1_words", 32'(words_written), 32'd1);
      send_word(32'h04030201);
      expect_write("w2", BASE + 32'h4, 32'h04030201, 4'hF);

      // flush paths
      send_byte(8'hAA); send_byte(8'hBB);
      flush = 1'b1; step(); flush = 1'b0;
      expect_write("fl2", BASE + 32'h8, 32'h0000BBAA, 4'b0011);
      ws0 = wr_seen;
      flush = 1'b1; step(); flush = 1'b0;
      repeat (4) step();
      chk("fl0_nowrite", 32'(wr_seen), 32'(ws0));
      rx_data = 8'hCC; rx_valid = 1'b1; flush = 1'b1; step(); rx_valid = 1'b0; flush = 1'b0;
      expect_write("flrx", BASE + 32'hC, 32'h000000CC, 4'b0001);
      ws0 = wr_seen;
      send_byte(8'hD0); send_byte(8'hD1); send_byte(8'hD2);
      rx_data = 8'hD3; rx_valid = 1'b1; flush = 1'b1; step(); rx_valid = 1'b0; flush = 1'b0;
      expect_write("fl4", BASE + 32'h10, 32'hD3D2D1D0, 4'hF);
      repeat (4) step();
      chk("fl4_single", 32'(wr_seen), 32'(ws0 + 1));
      chk("fl_words",   32'(words_written), 32'd5);

      // fill the FIFO with no grant, then overrun
      mem.UART_enable = 1'b0;
      for (int w = 0; w < 4; w++) send_word(32'h13121110 + 32'(w) * 32'h04040404);
      chk("full_set", 32'(fifo_full), 32'd1);
      chk("ovr_pre",  32'(overrun), 32'd0);
      send_word(32'h23222120);
      chk("ovr_set",  32'(overrun), 32'd1);
      chk("ovr_nowr", 32'(mem.write_from_UART), 32'd0);
      mem.UART_enable = 1'b1;
      for (int w = 0; w < 4; w++)
         expect_write("drain", BASE + 32'h14 + 32'(w) * 32'd4,
                      32'h13121110 + 32'(w) * 32'h04040404, 4'hF);
      repeat (3) step();
      chk("drain_full",  32'(fifo_full), 32'd0);
      chk("drain_words", 32'(words_written), 32'd9);
      chk("drain_ovr",   32'(overrun), 32'd1);
      chk("drain_idle",  32'(mem.write_from_UART), 32'd0);

      // stall in REQ: grant low 3 cycles, then busy 2 cycles
      send_word(32'hA3A2A1A0);
      wait_req("stall");
      mem.UART_enable = 1'b0;
      ws0 = wr_seen;
      repeat (3) begin
         step();
         chk("stall_en_wr",   32'(mem.write_from_UART), 32'd1);
         chk("stall_en_adr",  mem.adr_from_UART, BASE + 32'h24);
         chk("stall_en_data", mem.data_from_UART, 32'hA3A2A1A0);
      end
      mem.UART_enable = 1'b1; mem.mem_busy = 1'b1;
      repeat (2) begin
         step();
         chk("stall_bz_wr",  32'(mem.write_from_UART), 32'd1);
         chk("stall_bz_adr", mem.adr_from_UART, BASE + 32'h24);
         chk("stall_bz_sel", 32'(mem.sel_from_UART), 32'hF);
      end
      mem.mem_busy = 1'b0;
      step();
      chk("stall_gap",   32'(mem.write_from_UART), 32'd0);
      chk("stall_once",  32'(wr_seen), 32'(ws0 + 1));
      chk("stall_words", 32'(words_written), 32'd10);
      step(); step();
      chk("stall_idle",  32'(mem.write_from_UART), 32'd0);
      chk("stall_nodup", 32'(wr_seen), 32'(ws0 + 1));

      // load_start abandons a pending write and clears partial assembly
      mem.UART_enable = 1'b0;
      send_word(32'hDEADBEEF);
      send_byte(8'h55);
      mem.UART_enable = 1'b1;
      wait_req("ld");
      chk("ld_adr", mem.adr_from_UART, BASE + 32'h28);
      load_start = 1'b1; step(); load_start = 1'b0;
      chk("ld_write", 32'(mem.write_from_UART), 32'd0);
      chk("ld_words", 32'(words_written), 32'd0);
      chk("ld_ovr",   32'(overrun), 32'd0);
      chk("ld_full",  32'(fifo_full), 32'd0);
      ws0 = wr_seen;
      repeat (3) step();
      chk("ld_nowrite", 32'(wr_seen), 32'(ws0));

      // address wrap after SPAN/4 words
      for (int i = 0; i < 17; i++) begin
         send_word(32'h11223300 + 32'(i));
         expect_write("wrap", BASE + 32'((i % 16) * 4), 32'h11223300 + 32'(i), 4'hF);
      end
      chk("wrap_words", 32'(words_written), 32'd17);

      // async reset while packing and while in REQ
      mem.UART_enable = 1'b0;
      send_word(32'hCAFEF00D);
      send_byte(8'h77); send_byte(8'h88);
      mem.UART_enable = 1'b1;
      wait_req("ar");
      #2 nRst = 1'b0;
      #1;
      chk("ar_write", 32'(mem.write_from_UART), 32'd0);
      chk("ar_adr",   mem.adr_from_UART, 32'd0);
      chk("ar_data",  mem.data_from_UART, 32'd0);
      chk("ar_sel",   32'(mem.sel_from_UART), 32'd0);
      chk("ar_words", 32'(words_written), 32'd0);
      step(); step();
      nRst = 1'b1;
      step();
      chk("ar_idle", 32'(mem.write_from_UART), 32'd0);
      send_word(32'h04030201);
      expect_write("ar_restart", BASE, 32'h04030201, 4'hF);
      chk("ar_words1", 32'(words_written), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
